// File: rtl/cnn_window_stream_if.sv
// Handshake bundle for cnn_window_stream: frame config, raster pixel stream in, KxK window stream out.
// The DUT side uses the slave modport; the stream source/sink side uses master.
interface cnn_window_stream_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int KMAX   = 5,
    parameter int SMAX   = 2,
    parameter int MAX_W  = 64,
    parameter int MAX_H  = 64
) ();
    localparam int PIX_W = CH * DATA_W;
    localparam int WIN_W = KMAX * KMAX * PIX_W;

    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [$clog2(MAX_W+1)-1:0]   cfg_img_w;
    logic [$clog2(MAX_H+1)-1:0]   cfg_img_h;
    logic [$clog2(KMAX+1)-1:0]    cfg_kernel;
    logic [$clog2(SMAX+1)-1:0]    cfg_stride;
    logic [$clog2(KMAX)-1:0]      cfg_pad;
    logic                         pix_valid;
    logic                         pix_ready;
    logic [PIX_W-1:0]             pix_data;
    logic                         win_valid;
    logic                         win_ready;
    logic [WIN_W-1:0]             win_data;
    logic                         win_last;
    logic                         busy;
    logic                         cfg_err;

    modport slave (
        input  cfg_valid, cfg_img_w, cfg_img_h, cfg_kernel, cfg_stride, cfg_pad,
        input  pix_valid, pix_data, win_ready,
        output cfg_ready, pix_ready, win_valid, win_data, win_last, busy, cfg_err
    );

    modport master (
        output cfg_valid, cfg_img_w, cfg_img_h, cfg_kernel, cfg_stride, cfg_pad,
        output pix_valid, pix_data, win_ready,
        input  cfg_ready, pix_ready, win_valid, win_data, win_last, busy, cfg_err
    );
endinterface

// File: rtl/cnn_window_stream.sv
// Ring line buffer emitting zero-padded KxK windows in raster order; window registered 1 cycle after its last pixel.
// Input stalls only when the next write row is still needed; output holds stable under win_ready=0.
module cnn_window_stream #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int KMAX   = 5,
    parameter int SMAX   = 2,
    parameter int MAX_W  = 64,
    parameter int MAX_H  = 64
) (
    input  logic               clk,
    input  logic               rst,
    cnn_window_stream_if.slave bus
);
    localparam int PIX_W = CH * DATA_W;
    localparam int NROW  = KMAX + SMAX;
    localparam int WW    = $clog2(MAX_W + 1);
    localparam int HW    = $clog2(MAX_H + 1);
    localparam int KW    = $clog2(KMAX + 1);
    localparam int SW    = $clog2(SMAX + 1);
    localparam int PW    = $clog2(KMAX);
    localparam int CW    = $clog2(MAX_W + MAX_H + 4*KMAX + 4*SMAX + 1);
    localparam int RI    = $clog2(NROW);
    localparam int RW    = $clog2(2*NROW);
    localparam int XW    = $clog2(MAX_W);

    localparam logic [RW-1:0] NROW_R = RW'(NROW);

    typedef struct packed {
        logic [WW-1:0] w;
        logic [HW-1:0] h;
        logic [KW-1:0] k;
        logic [SW-1:0] s;
        logic [PW-1:0] p;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;
    cfg_t   cfg;

    logic [PIX_W-1:0] mem [NROW][MAX_W];

    logic [WW-1:0] in_x;
    logic [HW-1:0] in_y;
    logic [RI-1:0] wr_slot;
    logic [CW-1:0] col_start, row_start;
    logic [RW-1:0] top_slot;
    logic          out_done, last_hs_done;

    logic cfg_hs, pix_hs, win_hs, cfg_bad, last_pix, last_col, last_row, avail, load;
    logic [CW-1:0] wp, hp, kp, sp, pp;
    logic [CW-1:0] nw, nh, nk, np;
    logic [CW-1:0] in_xp, in_yp, col_end, row_end, xmax, ymax;
    logic [RW-1:0] slot_adv, top_slot_nxt;
    logic [KMAX*KMAX*PIX_W-1:0] taps;

    assign wp = CW'(cfg.w);
    assign hp = CW'(cfg.h);
    assign kp = CW'(cfg.k);
    assign sp = CW'(cfg.s);
    assign pp = CW'(cfg.p);

    assign nw = CW'(bus.cfg_img_w);
    assign nh = CW'(bus.cfg_img_h);
    assign nk = CW'(bus.cfg_kernel);
    assign np = CW'(bus.cfg_pad);

    assign cfg_bad = (bus.cfg_kernel == '0) || (bus.cfg_stride == '0)
                  || (bus.cfg_stride > SW'(SMAX)) || (bus.cfg_kernel > KW'(KMAX))
                  || (np >= nk) || (bus.cfg_img_w == '0) || (bus.cfg_img_h == '0)
                  || (bus.cfg_img_w > WW'(MAX_W)) || (bus.cfg_img_h > HW'(MAX_H))
                  || (nw + np + np < nk) || (nh + np + np < nk);

    assign cfg_hs = bus.cfg_valid && bus.cfg_ready;
    assign pix_hs = bus.pix_valid && bus.pix_ready;
    assign win_hs = bus.win_valid && bus.win_ready;

    assign last_pix = (in_x == cfg.w - WW'(1)) && (in_y == cfg.h - HW'(1));

    // All geometry is in padded coordinates so nothing goes negative.
    assign in_xp   = CW'(in_x) + pp;
    assign in_yp   = CW'(in_y) + pp;
    assign col_end = col_start + kp - CW'(1);
    assign row_end = row_start + kp - CW'(1);
    assign xmax    = (col_end < pp + wp) ? col_end : pp + wp - CW'(1);
    assign ymax    = (row_end < pp + hp) ? row_end : pp + hp - CW'(1);
    assign avail   = (in_yp > ymax) || ((in_yp == ymax) && (in_xp > xmax));

    assign last_col = (col_start + sp + kp) > (wp + pp + pp);
    assign last_row = (row_start + sp + kp) > (hp + pp + pp);

    assign load = (state != IDLE) && !out_done && avail && (!bus.win_valid || bus.win_ready);

    assign slot_adv     = top_slot + RW'(cfg.s);
    assign top_slot_nxt = (slot_adv >= NROW_R) ? slot_adv - NROW_R : slot_adv;

    // Writing row in_y evicts row in_y-NROW; hold off while the current window row still reads it.
    assign bus.pix_ready = (state == RUN) && (out_done || (in_yp < row_start + CW'(NROW)));

    always_comb begin
        state_nxt     = state;
        bus.cfg_ready = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid && !cfg_bad) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (pix_hs && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (last_hs_done || (win_hs && bus.win_last)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    for (genvar r = 0; r < KMAX; r++) begin : g_row
        logic [CW-1:0] py;
        logic          row_ok;
        logic [RW-1:0] slot_sum;
        logic [RI-1:0] slot;
        assign py       = row_start + CW'(r);
        assign row_ok   = (KW'(r) < cfg.k) && (py >= pp) && (py < pp + hp);
        assign slot_sum = top_slot + RW'(r);
        assign slot     = RI'((slot_sum >= NROW_R) ? slot_sum - NROW_R : slot_sum);
        for (genvar c = 0; c < KMAX; c++) begin : g_col
            logic [CW-1:0] px;
            logic [XW-1:0] ix;
            logic          ok;
            assign px = col_start + CW'(c);
            assign ix = XW'(px - pp);
            assign ok = row_ok && (KW'(c) < cfg.k) && (px >= pp) && (px < pp + wp);
            assign taps[(r*KMAX + c)*PIX_W +: PIX_W] = ok ? mem[slot][ix] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_hs) mem[wr_slot][XW'(in_x)] <= bus.pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg           <= '0;
            bus.cfg_err   <= 1'b0;
            in_x          <= '0;
            in_y          <= '0;
            wr_slot       <= '0;
            col_start     <= '0;
            row_start     <= '0;
            top_slot      <= '0;
            out_done      <= 1'b0;
            last_hs_done  <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_last  <= 1'b0;
            bus.win_data  <= '0;
        end else begin
            if (cfg_hs) begin
                bus.cfg_err <= cfg_bad;
                if (!cfg_bad) begin
                    cfg.w        <= bus.cfg_img_w;
                    cfg.h        <= bus.cfg_img_h;
                    cfg.k        <= bus.cfg_kernel;
                    cfg.s        <= bus.cfg_stride;
                    cfg.p        <= bus.cfg_pad;
                    in_x         <= '0;
                    in_y         <= '0;
                    wr_slot      <= '0;
                    col_start    <= '0;
                    row_start    <= '0;
                    // top_slot is (first window row - P) mod NROW, which starts negative when padded
                    top_slot     <= (bus.cfg_pad == '0) ? '0 : NROW_R - RW'(bus.cfg_pad);
                    out_done     <= 1'b0;
                    last_hs_done <= 1'b0;
                end
            end

            if (pix_hs) begin
                if (in_x == cfg.w - WW'(1)) begin
                    in_x    <= '0;
                    in_y    <= in_y + HW'(1);
                    wr_slot <= (wr_slot == RI'(NROW - 1)) ? '0 : wr_slot + RI'(1);
                end else begin
                    in_x <= in_x + WW'(1);
                end
            end

            if (load) begin
                bus.win_valid <= 1'b1;
                bus.win_data  <= taps;
                bus.win_last  <= last_col && last_row;
                if (last_col) begin
                    col_start <= '0;
                    if (last_row) begin
                        out_done <= 1'b1;
                    end else begin
                        row_start <= row_start + sp;
                        top_slot  <= top_slot_nxt;
                    end
                end else begin
                    col_start <= col_start + sp;
                end
            end else if (win_hs) begin
                bus.win_valid <= 1'b0;
                bus.win_last  <= 1'b0;
            end

            if (win_hs && bus.win_last) last_hs_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cnn_window_stream.sv
// Directed + randomized bench for cnn_window_stream: reference windows queued per frame, compared on each window handshake.
module tb_cnn_window_stream;
    localparam int DATA_W = 8;
    localparam int CH     = 4;
    localparam int KMAX   = 5;
    localparam int SMAX   = 2;
    localparam int MAX_W  = 64;
    localparam int MAX_H  = 64;
    localparam int PIX_W  = CH * DATA_W;
    localparam int NTAP   = KMAX * KMAX;
    localparam int WW     = $clog2(MAX_W + 1);
    localparam int HW     = $clog2(MAX_H + 1);
    localparam int KW     = $clog2(KMAX + 1);
    localparam int SW     = $clog2(SMAX + 1);
    localparam int PW     = $clog2(KMAX);

    typedef struct packed {
        logic                    last;
        logic [NTAP*PIX_W-1:0]   data;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_window_stream_if #(.DATA_W(DATA_W), .CH(CH), .KMAX(KMAX), .SMAX(SMAX),
                           .MAX_W(MAX_W), .MAX_H(MAX_H)) bus ();

    cnn_window_stream #(.DATA_W(DATA_W), .CH(CH), .KMAX(KMAX), .SMAX(SMAX),
                        .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   win_seen = 0;
    bit   rnd_ready = 1'b0;
    win_t exp_q [$];
    logic [PIX_W-1:0] img [MAX_W*MAX_H];
    logic [NTAP*PIX_W-1:0] first_win;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        bus.win_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.win_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    logic                  stall_prev = 1'b0;
    logic                  last_prev;
    logic [NTAP*PIX_W-1:0] data_prev;
    win_t                  mon_e;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", bus.win_valid, 1);
                check("hold_data", bus.win_data === data_prev, 1);
                check("hold_last", bus.win_last, last_prev);
            end
            if (bus.win_valid && bus.win_ready) begin
                check("win_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    if (win_seen == 0) first_win = bus.win_data;
                    for (int t = 0; t < NTAP; t++)
                        check($sformatf("win%0d_tap%0d", win_seen, t),
                              bus.win_data[t*PIX_W +: PIX_W], mon_e.data[t*PIX_W +: PIX_W]);
                    check($sformatf("win%0d_last", win_seen), bus.win_last, mon_e.last);
                end
                win_seen++;
            end
            stall_prev = bus.win_valid && !bus.win_ready;
            data_prev  = bus.win_data;
            last_prev  = bus.win_last;
        end
    end

    task automatic push_expected(input int w, input int h, input int k, input int s, input int p);
        int   ow, oh, py, px;
        win_t e;
        ow = (w + 2*p - k) / s + 1;
        oh = (h + 2*p - k) / s + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                e.data = '0;
                for (int r = 0; r < k; r++) begin
                    for (int c = 0; c < k; c++) begin
                        py = oy*s + r - p;
                        px = ox*s + c - p;
                        if (py >= 0 && py < h && px >= 0 && px < w)
                            e.data[(r*KMAX + c)*PIX_W +: PIX_W] = img[py*w + px];
                    end
                end
                e.last = (oy == oh - 1) && (ox == ow - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_cfg(input int w, input int h, input int k, input int s, input int p);
        int cyc;
        cyc = 0;
        bus.cfg_valid  = 1'b1;
        bus.cfg_img_w  = WW'(w);
        bus.cfg_img_h  = HW'(h);
        bus.cfg_kernel = KW'(k);
        bus.cfg_stride = SW'(s);
        bus.cfg_pad    = PW'(p);
        @(negedge clk);
        while (!bus.cfg_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) check("cfg_accept_timeout", bus.cfg_ready, 1);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [PIX_W-1:0] d);
        int cyc;
        cyc = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        @(negedge clk);
        while (!bus.pix_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check("pix_accept_timeout", bus.pix_ready, 1);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic fill_img(input int n, input bit rnd_img);
        for (int i = 0; i < n; i++)
            img[i] = rnd_img ? PIX_W'($urandom()) : {CH{DATA_W'(i)}};
    endtask

    task automatic run_frame(input int w, input int h, input int k, input int s, input int p,
                             input bit rnd_pix, input bit rnd_img, input string tag);
        int nexp, cyc;
        fill_img(w*h, rnd_img);
        exp_q.delete();
        win_seen = 0;
        push_expected(w, h, k, s, p);
        nexp = exp_q.size();
        send_cfg(w, h, k, s, p);
        @(negedge clk);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_cfg_err"}, bus.cfg_err, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < w*h; i++) begin
            if (rnd_pix) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_pixel(img[i]);
        end
        cyc = 0;
        while (bus.busy && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_win_count"}, win_seen, nexp);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_img_w  = '0;
        bus.cfg_img_h  = '0;
        bus.cfg_kernel = '0;
        bus.cfg_stride = '0;
        bus.cfg_pad    = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_last", bus.win_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_win_data_zero", bus.win_data == '0, 1);
        @(posedge clk);
        #1;

        run_frame(4, 4, 3, 1, 0, 1'b0, 1'b0, "k3p0");
        check("k3p0_tap00", first_win[0 +: PIX_W], {CH{8'd0}});
        check("k3p0_tap11", first_win[(1*KMAX + 1)*PIX_W +: PIX_W], {CH{8'd5}});
        check("k3p0_tap22", first_win[(2*KMAX + 2)*PIX_W +: PIX_W], {CH{8'd10}});

        run_frame(4, 4, 3, 1, 1, 1'b0, 1'b0, "k3p1");
        check("k3p1_tap00", first_win[0 +: PIX_W], {CH{8'd0}});
        check("k3p1_tap11", first_win[(1*KMAX + 1)*PIX_W +: PIX_W], {CH{8'd0}});
        check("k3p1_tap22", first_win[(2*KMAX + 2)*PIX_W +: PIX_W], {CH{8'd5}});

        run_frame(5, 5, 3, 2, 0, 1'b0, 1'b0, "k3s2");
        run_frame(3, 2, 1, 1, 0, 1'b0, 1'b0, "k1");
        run_frame(4, 6, 3, 2, 0, 1'b1, 1'b0, "extra_rows");

        rnd_ready = 1'b1;
        run_frame(8, 8, 5, 2, 2, 1'b1, 1'b1, "rnd_k5s2p2");
        rnd_ready = 1'b0;

        send_cfg(4, 4, 3, 1, 3);
        bus.pix_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("bad_cfg_err", bus.cfg_err, 1);
        check("bad_cfg_ready", bus.cfg_ready, 1);
        check("bad_busy", bus.busy, 0);
        check("bad_pix_ready", bus.pix_ready, 0);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;

        exp_q.delete();
        win_seen = 0;
        fill_img(16, 1'b0);
        send_cfg(4, 4, 3, 1, 0);
        @(negedge clk);
        check("abort_cfg_err_clear", bus.cfg_err, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send_pixel(img[i]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_pix_ready", bus.pix_ready, 0);
        check("abort_win_valid", bus.win_valid, 0);
        check("abort_cfg_ready", bus.cfg_ready, 1);
        check("abort_no_windows", win_seen, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(6, 5, 2, 2, 1, 1'b1, 1'b1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
